// File: rtl/seg_scan_ctrl_pkg.sv
// seg_scan_ctrl_pkg
// Shared definitions for the four-digit seven-segment scan controller:
// digit count, index width, the "all anodes off" pattern, the scanner
// state encoding and the index-to-anode mapping used by the board's
// 2-to-4 active-low digit decoder.
package seg_scan_ctrl_pkg;

   localparam int NDIG  = 4;
   localparam int IDX_W = 2;

   localparam logic [NDIG-1:0] ANODE_OFF = 4'b1111;

   // ST_IDLE  : scanner parked, display dark
   // ST_BLANK : first BLANK cycles of a digit slot, anodes off to avoid ghosting
   // ST_SHOW  : remainder of the slot, digit driven if its mask bit is set
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_SHOW  = 2'd2
   } scan_state_t;

   // Active-low one-hot anode drive for a digit index:
   // 0 -> 1110, 1 -> 1101, 2 -> 1011, 3 -> 0111.
   function automatic logic [NDIG-1:0] anode_pattern(input logic [IDX_W-1:0] idx);
      logic [NDIG-1:0] one_hot;
      one_hot = NDIG'(1) << idx;
      return ~one_hot;
   endfunction

endpackage

// File: rtl/seg_scan_ctrl_scan_timer.sv
// scan_timer
// Slot counter and digit index for the scan controller. The counter runs
// 0..PRESCALE-1 while enabled and advances the digit index on each wrap.
// All outputs describe the position the scanner will occupy after the
// coming clock edge, so the parent can register its outputs in step with
// this block's own registers.
//
// Ports:
//   clk         system clock
//   rst         synchronous active-high reset
//   en          scan enable; 0 parks the counter and index at zero
//   restart     scanner was idle last cycle; the next enabled cycle
//               begins a fresh frame at digit 0
//   idx_next    digit index after the coming edge
//   frame_start coming edge begins a frame (index wraps 3->0, or restart)
//   in_blank    coming edge lands inside the blanking part of the slot
module scan_timer
   import seg_scan_ctrl_pkg::*;
#(
   parameter int PRESCALE = 50000,
   parameter int BLANK    = 500
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             restart,
   output logic [IDX_W-1:0] idx_next,
   output logic             frame_start,
   output logic             in_blank
);

   localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;
   logic [IDX_W-1:0] idx;
   logic             slot_wrap;
   logic             restart_start;

   // Next counter/index. A disabled scanner is forced to digit 0 slot
   // start; leaving idle restarts there and counts as a frame start so
   // pending data is applied immediately on re-enable.
   always_comb begin
      cnt_next      = cnt;
      idx_next      = idx;
      slot_wrap     = 1'b0;
      restart_start = 1'b0;
      if (!en) begin
         cnt_next = '0;
         idx_next = '0;
      end else if (restart) begin
         cnt_next      = '0;
         idx_next      = '0;
         restart_start = 1'b1;
      end else if (cnt == CNT_W'(PRESCALE - 1)) begin
         cnt_next  = '0;
         idx_next  = idx + 1'b1;
         slot_wrap = 1'b1;
      end else begin
         cnt_next = cnt + 1'b1;
      end
   end

   // A slot wrap that lands back on digit 0 is the 3->0 frame boundary.
   assign frame_start = restart_start | (slot_wrap & (idx_next == '0));
   assign in_blank    = (cnt_next < CNT_W'(BLANK));

   // Counter and index registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         idx <= '0;
      end else begin
         cnt <= cnt_next;
         idx <= idx_next;
      end
   end

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
// Time-multiplexed scan controller for a 4-digit common-anode
// seven-segment display. Drives the 2-to-4 active-low digit decoder
// (digit_sel/dec_en), the anode lines and the nibble for the segment
// encoder. Each digit slot begins with a blanking interval. New display
// data is staged in a pending buffer and only takes effect at a frame
// start, so a frame is never shown half old / half new.
//
// Ports:
//   clk         system clock
//   rst         synchronous active-high reset
//   en          scan enable; 0 blanks the display and parks the scanner
//   load        single-cycle strobe capturing load_data/load_mask
//   load_data   four nibbles, digit k in bits [4k+3:4k]
//   load_mask   per-digit light enable, bit k = digit k
//   load_ack    one-cycle pulse when pending data reaches the display
//   digit_sel   binary digit index to the decoder
//   dec_en      decoder enable
//   anode_n     active-low one-hot digit drive
//   nibble      value of the current digit
//   frame_tick  one-cycle pulse on the first cycle of each frame
module seg_scan_ctrl
   import seg_scan_ctrl_pkg::*;
#(
   parameter int PRESCALE = 50000,
   parameter int BLANK    = 500
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        load,
   input  logic [15:0] load_data,
   input  logic [3:0]  load_mask,
   output logic        load_ack,
   output logic [1:0]  digit_sel,
   output logic        dec_en,
   output logic [3:0]  anode_n,
   output logic [3:0]  nibble,
   output logic        frame_tick
);

   scan_state_t state;
   scan_state_t state_next;

   logic [IDX_W-1:0] idx_next;
   logic             frame_start;
   logic             in_blank;
   logic             restart_scan;
   logic             apply;

   logic [15:0] pend_data;
   logic [3:0]  pend_mask;
   logic        pend_valid;
   logic [15:0] disp_data;
   logic [3:0]  disp_mask;
   logic [15:0] disp_data_next;
   logic [3:0]  disp_mask_next;

   logic [3:0]  anode_next;
   logic        dec_en_next;
   logic [1:0]  digit_sel_next;
   logic [3:0]  nibble_next;

   assign restart_scan = (state == ST_IDLE);

   scan_timer #(
      .PRESCALE (PRESCALE),
      .BLANK    (BLANK)
   ) u_scan_timer (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .restart     (restart_scan),
      .idx_next    (idx_next),
      .frame_start (frame_start),
      .in_blank    (in_blank)
   );

   // The pending set is promoted only on a frame start; the outputs below
   // use the promoted value so new data is visible from digit 0 onward.
   assign apply          = frame_start & pend_valid;
   assign disp_data_next = apply ? pend_data : disp_data;
   assign disp_mask_next = apply ? pend_mask : disp_mask;

   // Next state and next registered outputs. Outputs are decoded from the
   // state being entered so every output lines up with the scanner
   // position registered on the same edge.
   always_comb begin
      state_next     = ST_IDLE;
      anode_next     = ANODE_OFF;
      dec_en_next    = 1'b0;
      digit_sel_next = idx_next;
      nibble_next    = disp_data_next[{idx_next, 2'b00} +: 4];
      if (en) begin
         state_next = in_blank ? ST_BLANK : ST_SHOW;
      end
      case (state_next)
         ST_SHOW: begin
            if (disp_mask_next[idx_next]) begin
               dec_en_next = 1'b1;
               anode_next  = anode_pattern(idx_next);
            end
         end
         default: begin
            anode_next  = ANODE_OFF;
            dec_en_next = 1'b0;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Pending and display buffers. A load arriving on the same edge as an
   // apply becomes the next pending set, while the apply uses the old one.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_data  <= '0;
         pend_mask  <= '0;
         pend_valid <= 1'b0;
         disp_data  <= '0;
         disp_mask  <= '0;
      end else begin
         disp_data <= disp_data_next;
         disp_mask <= disp_mask_next;
         if (load) begin
            pend_data  <= load_data;
            pend_mask  <= load_mask;
            pend_valid <= 1'b1;
         end else if (apply) begin
            pend_valid <= 1'b0;
         end
      end
   end

   // Output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         anode_n    <= ANODE_OFF;
         digit_sel  <= '0;
         dec_en     <= 1'b0;
         nibble     <= '0;
         frame_tick <= 1'b0;
         load_ack   <= 1'b0;
      end else begin
         anode_n    <= anode_next;
         digit_sel  <= digit_sel_next;
         dec_en     <= dec_en_next;
         nibble     <= nibble_next;
         frame_tick <= frame_start;
         load_ack   <= apply;
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl
// Scoreboard bench for seg_scan_ctrl with a short slot (PRESCALE=8,
// BLANK=2). The driver issues one input vector per cycle and queues the
// hand-derived output expected after that edge; the monitor pops and
// compares one entry per cycle.
module tb_seg_scan_ctrl;

   localparam int P = 8;
   localparam int B = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic        load = 1'b0;
   logic [15:0] load_data = '0;
   logic [3:0]  load_mask = '0;
   logic        load_ack;
   logic [1:0]  digit_sel;
   logic        dec_en;
   logic [3:0]  anode_n;
   logic [3:0]  nibble;
   logic        frame_tick;

   // {anode_n, dec_en, digit_sel, nibble, frame_tick, load_ack}
   typedef struct {
      logic [12:0] exp_v;
      logic [12:0] care;
      string       tag;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   failures = 0;

   localparam logic [12:0] CARE_ALL  = 13'h1FFF;
   localparam logic [12:0] CARE_NONIB = 13'h1FC3;

   seg_scan_ctrl #(
      .PRESCALE (P),
      .BLANK    (B)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .load       (load),
      .load_data  (load_data),
      .load_mask  (load_mask),
      .load_ack   (load_ack),
      .digit_sel  (digit_sel),
      .dec_en     (dec_en),
      .anode_n    (anode_n),
      .nibble     (nibble),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   function automatic logic [12:0] packExp(input logic [3:0] an, input logic de,
                                           input logic [1:0] ds, input logic [3:0] nb,
                                           input logic ft, input logic ak);
      return {an, de, ds, nb, ft, ak};
   endfunction

   // Drive one cycle of inputs and queue the output expected after the edge.
   task automatic applyStimulus(input logic r, input logic e, input logic ld,
                                input logic [15:0] ldd, input logic [3:0] ldm,
                                input logic [12:0] ev, input logic [12:0] care,
                                input string tag);
      exp_t item;
      @(negedge clk);
      rst       = r;
      en        = e;
      load      = ld;
      load_data = ldd;
      load_mask = ldm;
      item.exp_v = ev;
      item.care  = care;
      item.tag   = tag;
      sb_q.push_back(item);
   endtask

   // Frame positions p0..p1-1 showing data d with mask m. Slot k = p/8,
   // cnt = p%8; cnt<2 is blank. A load is driven on the cycle at load_p.
   task automatic runFrame(input logic [15:0] d, input logic [3:0] m, input logic ack,
                           input int p0, input int p1, input int load_p,
                           input logic [15:0] ldd, input logic [3:0] ldm);
      logic [15:0] dv;
      logic [3:0]  oh;
      logic [3:0]  an;
      logic        lit;
      int          k;
      int          c;
      dv = d;
      for (int p = p0; p < p1; p++) begin
         k   = p / P;
         c   = p % P;
         lit = (c >= B) && m[k];
         oh  = 4'b0001 << k;
         an  = lit ? ~oh : 4'b1111;
         applyStimulus(1'b0, 1'b1, (p == load_p), ldd, ldm,
                       packExp(an, lit, 2'(k), dv[4*k +: 4], (p == 0), (p == 0) && ack),
                       CARE_ALL, $sformatf("frame d=%h m=%b p=%0d", d, m, p));
      end
   endtask

   // Pop one expectation per cycle and compare the masked output vector.
   task automatic checkOutput();
      exp_t        item;
      logic [12:0] act;
      item = sb_q.pop_front();
      act  = {anode_n, dec_en, digit_sel, nibble, frame_tick, load_ack};
      checks++;
      if (((act ^ item.exp_v) & item.care) != 13'h0) begin
         failures++;
         $display("[TB] FAIL %s: got={an=%b de=%b ds=%0d nib=%h ft=%b ack=%b} want={an=%b de=%b ds=%0d nib=%h ft=%b ack=%b}",
                  item.tag, act[12:9], act[8], act[7:6], act[5:2], act[1], act[0],
                  item.exp_v[12:9], item.exp_v[8], item.exp_v[7:6], item.exp_v[5:2],
                  item.exp_v[1], item.exp_v[0]);
      end
   endtask

   // Monitor: sample just after each rising edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) checkOutput();
      end
   end

   initial begin
      logic [12:0] rst_exp;
      logic [12:0] idle_exp;
      rst_exp  = packExp(4'b1111, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0);
      idle_exp = packExp(4'b1111, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0);

      $display("[TB] start");
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 4'h0, rst_exp, CARE_ALL, "reset0");
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 4'h0, rst_exp, CARE_ALL, "reset1");

      // Load while idle, then enable: first frame applies it with one ack.
      applyStimulus(1'b0, 1'b0, 1'b1, 16'h4321, 4'b1111, idle_exp, CARE_NONIB, "idle load");
      runFrame(16'h4321, 4'b1111, 1'b1, 0, 32, -1, 16'h0, 4'h0);
      runFrame(16'h4321, 4'b1111, 1'b0, 0, 32, -1, 16'h0, 4'h0);

      // Partial mask: digits 1 and 3 dark.
      runFrame(16'h4321, 4'b1111, 1'b0, 0, 32, 3, 16'h8765, 4'b0101);
      runFrame(16'h8765, 4'b0101, 1'b1, 0, 32, -1, 16'h0, 4'h0);

      // Two loads in one frame: last one wins, single ack.
      runFrame(16'h8765, 4'b0101, 1'b0, 0, 20, 5, 16'hAAAA, 4'b1111);
      runFrame(16'h8765, 4'b0101, 1'b0, 20, 32, 20, 16'hBBBB, 4'b1111);
      runFrame(16'hBBBB, 4'b1111, 1'b1, 0, 32, -1, 16'h0, 4'h0);

      // Load coinciding with an apply.
      runFrame(16'hBBBB, 4'b1111, 1'b0, 0, 32, 10, 16'h1111, 4'b1111);
      runFrame(16'h1111, 4'b1111, 1'b1, 0, 32, 0, 16'h5555, 4'b1111);
      runFrame(16'h5555, 4'b1111, 1'b1, 0, 32, -1, 16'h0, 4'h0);

      // Drop enable at cnt=5 of digit 2, idle, then re-enable.
      runFrame(16'h5555, 4'b1111, 1'b0, 0, 22, -1, 16'h0, 4'h0);
      for (int i = 0; i < 3; i++)
         applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 4'h0, idle_exp, CARE_NONIB,
                       $sformatf("en off %0d", i));
      runFrame(16'h5555, 4'b1111, 1'b0, 0, 32, -1, 16'h0, 4'h0);

      // Reset mid-SHOW with a pending load: pending discarded.
      runFrame(16'h5555, 4'b1111, 1'b0, 0, 11, 4, 16'h9999, 4'b1111);
      applyStimulus(1'b1, 1'b1, 1'b0, 16'h0, 4'h0, rst_exp, CARE_ALL, "reset mid show");
      applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 4'h0, idle_exp, CARE_NONIB, "idle after reset");
      runFrame(16'h0000, 4'b0000, 1'b0, 0, 32, -1, 16'h0, 4'h0);

      @(negedge clk);
      en = 1'b0;
      @(posedge clk);
      #2;
      checks++;
      if (sb_q.size() != 0) begin
         failures++;
         $display("[TB] FAIL scoreboard drain: got=%0d entries left want=0", sb_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
